// File: rtl/mux_arb_nto1.sv
// N-way, W-bit selecting mux with a registered output and valid/ready handshakes.
// Direct mode picks the source by index; round-robin mode arbitrates fairly among valid sources.
module mux_arb_nto1 #(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned NUM_IN = 8,
   localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_IN-1:0]         in_valid,
   input  logic [NUM_IN*WIDTH-1:0]   in_data,
   output logic [NUM_IN-1:0]         in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_src,
   input  logic                      out_ready
);

   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q,  out_data_d;
   logic [SEL_W-1:0]   out_src_q,   out_src_d;
   logic [SEL_W-1:0]   rr_ptr_q,    rr_ptr_d;

   logic               load_en_c;
   logic               xfer_c;
   logic               rr_found_c;
   logic [SEL_W-1:0]   rr_idx_c;
   logic               grant_valid_c;
   logic [SEL_W-1:0]   grant_idx_c;
   logic [WIDTH-1:0]   grant_data_c;

   assign load_en_c = !out_valid_q | out_ready;
   assign xfer_c    = load_en_c & grant_valid_c;

   // Round-robin search starting one past the last granted channel
   always_comb begin
      int unsigned idx;
      idx        = 0;
      rr_found_c = 1'b0;
      rr_idx_c   = '0;
      for (int unsigned k = 1; k <= NUM_IN; k++) begin
         idx = (32'(rr_ptr_q) + k) % NUM_IN;
         if (!rr_found_c && in_valid[SEL_W'(idx)]) begin
            rr_found_c = 1'b1;
            rr_idx_c   = SEL_W'(idx);
         end
      end
   end

   // Grant selection for the active mode
   always_comb begin
      grant_valid_c = 1'b0;
      grant_idx_c   = '0;
      if (mode) begin
         grant_valid_c = rr_found_c;
         grant_idx_c   = rr_idx_c;
      end else if (32'(sel) < NUM_IN) begin
         grant_valid_c = in_valid[sel];
         grant_idx_c   = sel;
      end
   end

   always_comb begin
      grant_data_c = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (grant_idx_c == SEL_W'(i)) begin
            grant_data_c = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Ready is one-hot on the granted channel and gated off during reset
   always_comb begin
      in_ready = '0;
      if (reset_n && xfer_c) begin
         in_ready[grant_idx_c] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (load_en_c) begin
         out_valid_d = grant_valid_c;
         if (grant_valid_c) begin
            out_data_d = grant_data_c;
            out_src_d  = grant_idx_c;
            if (mode) begin
               rr_ptr_d = grant_idx_c;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= SEL_W'(NUM_IN - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Randomised bench for mux_arb_nto1 against a behavioural model, plus directed literal checks.
module tb_mux_arb_nto1;

   localparam int unsigned W = 32;
   localparam int unsigned N = 8;
   localparam int unsigned S = 3;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             mode = 1'b0;
   logic [S-1:0]     sel = '0;
   logic [N-1:0]     in_valid = '0;
   logic [N*W-1:0]   in_data = '0;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [S-1:0]     out_src;
   logic             out_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   // Model of the visible output register and the arbitration pointer
   bit          m_valid = 1'b0;
   logic [W-1:0] m_data = '0;
   int          m_src   = 0;
   int          m_ptr   = N - 1;

   mux_arb_nto1 #(.WIDTH(W), .NUM_IN(N)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = N - 1;
   endtask

   function automatic void model_grant(output bit gv, output int g);
      gv = 1'b0;
      g  = 0;
      if (!mode) begin
         if (int'(sel) < N && in_valid[sel]) begin
            gv = 1'b1;
            g  = int'(sel);
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!gv && in_valid[idx]) begin
               gv = 1'b1;
               g  = idx;
            end
         end
      end
   endfunction

   // Compare outputs against the model mid-cycle, then advance the model across the next edge
   task automatic tick();
      bit         gv;
      int         g;
      bit         le;
      logic [N-1:0] er;
      #1;
      model_grant(gv, g);
      le = !m_valid || out_ready;
      er = (reset_n && le && gv) ? N'(1 << g) : '0;
      cmp("in_ready",  in_ready,  er);
      cmp("out_valid", out_valid, m_valid);
      cmp("out_data",  out_data,  m_data);
      cmp("out_src",   out_src,   m_src);
      if (!reset_n) begin
         model_reset();
      end else if (le) begin
         m_valid = gv;
         if (gv) begin
            m_data = in_data[g*W +: W];
            m_src  = g;
            if (mode) m_ptr = g;
         end
      end
      @(negedge clk);
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom();
   endtask

   initial begin
      rand_data();
      repeat (2) @(negedge clk);

      // Reset held with every channel valid
      in_valid  = '1;
      mode      = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      cmp("rst_valid", out_valid, 0);
      cmp("rst_data",  out_data,  0);
      cmp("rst_ready", in_ready,  0);

      // Round-robin fairness from reset: 0..7 then 0, no bubbles
      reset_n = 1'b1;
      tick();
      for (int i = 0; i <= 8; i++) begin
         cmp("rr_src",   out_src,   i % 8);
         cmp("rr_valid", out_valid, 1);
         if (i < 8) tick();
      end

      // Skip and wrap between channels 1 and 7
      in_valid = 8'b1000_0010;
      for (int i = 0; i < 4; i++) begin
         tick();
         cmp("rr_wrap_src", out_src, (i % 2 == 0) ? 1 : 7);
         cmp("rr_wrap_valid", out_valid, 1);
      end

      // Direct select
      mode     = 1'b0;
      sel      = 3'd5;
      in_valid = 8'hFF;
      in_data[5*W +: W] = 32'hA5A5_0005;
      tick();
      cmp("dir_data",  out_data, 32'hA5A5_0005);
      cmp("dir_src",   out_src,  5);
      cmp("dir_ready", in_ready, 8'h20);
      sel      = 3'd7;
      in_valid = 8'h7F;
      tick();
      cmp("dir_nogrant", out_valid, 0);

      // Back-pressure holds the word and blocks every producer
      sel      = 3'd5;
      in_valid = 8'hFF;
      in_data[5*W +: W] = 32'h1234_5605;
      tick();
      cmp("bp_load", out_data, 32'h1234_5605);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         tick();
         cmp("bp_hold_data",  out_data, 32'h1234_5605);
         cmp("bp_hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      in_data[5*W +: W] = 32'hCAFE_0005;
      tick();
      cmp("bp_release", out_data, 32'hCAFE_0005);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         mode      = 1'($urandom_range(0, 1));
         sel       = S'($urandom_range(0, N - 1));
         in_valid  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom());
         out_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         tick();
      end

      // Asynchronous reset while a word is stalled
      mode      = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      tick();
      cmp("stall_valid", out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      cmp("async_valid", out_valid, 0);
      cmp("async_data",  out_data,  0);
      cmp("async_ready", in_ready,  0);
      model_reset();
      @(negedge clk);
      tick();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      tick();
      cmp("rst_restart_src",   out_src,   0);
      cmp("rst_restart_valid", out_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
